// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping FIFO pointer, cleared by reset or flush
module fifo_ptr #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_with_flush.sv
// rtl/sync_fifo_with_flush.sv - single-clock valid/ready FIFO with synchronous flush
// Optional macro SYNC_FIFO_BYPASS_EN: empty-FIFO combinational pass-through.
module sync_fifo_with_flush #(
    parameter int                   DATA_LEN = 32,
    parameter int                   DEPTH    = 4,
    parameter logic [DATA_LEN-1:0]  RST_DATA = '0,
    localparam int                  PW       = $clog2(DEPTH),
    localparam int                  CW       = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic [CW-1:0]       count
);

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                push_en;
    logic                pop_en;
    logic                empty;
    logic                full;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

`ifdef SYNC_FIFO_BYPASS_EN
    logic bypass;

    // Empty FIFO with a ready reader: hand the word straight across, nothing stored.
    assign bypass    = empty && !flush && in_valid && out_ready;
    assign in_ready  = !full && !flush;
    assign out_valid = (!empty && !flush) || bypass;
    assign out_data  = bypass ? in_data : (!empty && !flush) ? mem[rd_ptr] : RST_DATA;
    assign push_en   = in_valid && in_ready && !bypass;
    assign pop_en    = out_valid && out_ready && !bypass;
`else
    assign in_ready  = !full && !flush;
    assign out_valid = !empty && !flush;
    assign out_data  = out_valid ? mem[rd_ptr] : RST_DATA;
    assign push_en   = in_valid && in_ready;
    assign pop_en    = out_valid && out_ready;
`endif

    // Storage is deliberately never reset; only pointers and count track validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inc   (push_en),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inc   (pop_en),
        .ptr   (rd_ptr)
    );

endmodule

// File: tb/tb_sync_fifo_with_flush.sv
// tb/tb_sync_fifo_with_flush.sv - directed bench for sync_fifo_with_flush
module tb_sync_fifo_with_flush;

    localparam int DATA_LEN = 32;
    localparam int DEPTH    = 4;
    localparam int CW       = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_data;
    logic [CW-1:0]       count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_with_flush #(
        .DATA_LEN (DATA_LEN),
        .DEPTH    (DEPTH),
        .RST_DATA ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic push(input logic [DATA_LEN-1:0] d);
        in_valid = 1'b1; in_data = d; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_fill_drain();
        logic [DATA_LEN-1:0] exp_d;
        for (int i = 0; i < 4; i++) push(32'hA1 + i);
        #1;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'hA1 + i;
            #1;
            total++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
                bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_d);
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++; $display("FAIL drain_empty got=%b/%h exp=0/0", out_valid, out_data);
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_full_pop();
        logic [DATA_LEN-1:0] exp_d;
        for (int i = 0; i < 4; i++) push(32'hB0 + i);
        in_valid = 1'b1; in_data = 32'hBF; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_in_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count got=%0d exp=3", count); end
        for (int i = 1; i < 4; i++) begin
            exp_d = 32'hB0 + i;
            #1;
            total++; if (out_data !== exp_d) begin bad++; $display("FAIL full_pop_data_%0d got=%h exp=%h", i, out_data, exp_d); end
            tick();
        end
        out_ready = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL full_pop_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_push_pop();
        push(32'hC0);
        push(32'hC1);
        in_valid = 1'b1; in_data = 32'hC2; out_ready = 1'b1;
        #1;
        total++; if (out_data !== 32'hC0) begin bad++; $display("FAIL pp_oldest got=%h exp=c0", out_data); end
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL pp_count got=%0d exp=2", count); end
        total++; if (out_data !== 32'hC1) begin bad++; $display("FAIL pp_next got=%h exp=c1", out_data); end
        tick();
        #1;
        total++; if (out_data !== 32'hC2) begin bad++; $display("FAIL pp_last got=%h exp=c2", out_data); end
        tick();
        out_ready = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL pp_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_LEN-1:0] exp_d;
        push(32'hD0);
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_data = 32'hD0 + i; out_ready = 1'b1;
            exp_d = 32'hD0 + i - 1;
            #1;
            total++; if (out_data !== exp_d || count !== 3'd1) begin
                bad++; $display("FAIL b2b_%0d got=%h/%0d exp=%h/1", i, out_data, count, exp_d);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        total++; if (out_data !== 32'hDA) begin bad++; $display("FAIL b2b_tail got=%h exp=da", out_data); end
        tick();
        out_ready = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push(32'hE0 + i);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hEE; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        push(32'hE5);
        out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== 32'hE5) begin
            bad++; $display("FAIL flush_after got=%b/%h exp=1/e5", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_priority();
        push(32'hF0);
        push(32'hF1);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'hF2;
        tick();
        idle();
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rstpri_count got=%0d exp=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstpri_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++; $display("FAIL rstpri_out got=%b/%h exp=0/0", out_valid, out_data);
        end
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        #1;
`ifdef SYNC_FIFO_BYPASS_EN
        total++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin
            bad++; $display("FAIL bypass_out got=%b/%h exp=1/55", out_valid, out_data);
        end
`else
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++; $display("FAIL no_bypass_out got=%b/%h exp=0/0", out_valid, out_data);
        end
`endif
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bypass_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
`ifdef SYNC_FIFO_BYPASS_EN
        total++; if (count !== 3'd0) begin bad++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
        total++; if (count !== 3'd1 || out_data !== 32'h55) begin
            bad++; $display("FAIL no_bypass_stored got=%0d/%h exp=1/55", count, out_data);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_pop();
        test_push_pop();
        test_back_to_back();
        test_flush();
        test_reset_priority();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
